pkt_header_parser: RTL and testbench
====================================

# pkt_header_parser

Ingress-side counterpart of the deparser. Takes an AXI4-Stream packet, forwards it unchanged to the packet FIFO, and captures the first four 256b beats (128 bytes). It then looks up a 16-entry parse-action table indexed by the packet's VLAN ID and extracts up to 10 header fields into the 2B/4B/6B containers of a PHV. The PHV goes to the PHV FIFO in the layout the deparser consumes.

## Interface
- C_AXIS_DATA_WIDTH, 256, stream data width; fixed at 256.
- C_AXIS_TUSER_WIDTH, 128, stream tuser width.
- C_PKT_VEC_WIDTH, 1124, PHV width (12\*8\*8 + 20\*5 + 256).
- clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_axis_tdata / tkeep / tuser / tlast / tvalid  in  256 / 32 / 128 / 1 / 1  ingress packet; byte 0 is tdata[7:0].
- s_axis_tready  out  1  ingress ready.
- m_axis_tdata / tkeep / tuser / tlast / tvalid  out  256 / 32 / 128 / 1 / 1  packet to pkt FIFO.
- m_axis_tready  in  1  pkt FIFO not full.
- phv_out  out  1124  extracted PHV.
- phv_out_valid  out  1  PHV valid.
- phv_out_ready  in  1  PHV FIFO not full.
- ctrl_wr_en  in  1  parse-action table write strobe.
- ctrl_wr_addr  in  4  table entry.
- ctrl_wr_data  in  160  entry data; action i occupies [16\*i+:16], i = 0..9.

## Operation
- **Parse action (16b):**
  - [0] valid.
  - [3:1] container index 0..7.
  - [5:4] type: 01 = 2B, 10 = 4B, 11 = 6B, 00 = ignore.
  - [12:6] byte offset 0..127 into the captured 128 bytes.
  - [15:13] reserved.
- **Table:** 16 x 160b registers, all cleared on reset. A write takes effect the cycle after ctrl_wr_en.
- **PHV layout:**
  - [0+:128] = tuser of beat 0.
  - [129+:12] = vlan_id.
  - All other bits in [128,356) are 0.
  - 2B containers start at bit 356 (container k at 356+16k).
  - 4B containers start at bit 484 (484+32k).
  - 6B containers start at bit 740 (740+48k).
  - Containers with no action are 0.
- **VLAN ID:** vlan_id = {byte14[3:0], byte15} of beat 0. Table index = vlan_id[7:4].
- **Field byte order:** network order. The container MSB byte is packet byte `offset`; the LSB byte is byte `offset+n-1`, with n = 2, 4 or 6.
- **Out-of-range fields:**
  - Bytes past 127 read as 0.
  - Bytes in beats not received (packet shorter than 4 beats) read as 0.
  - The capture buffer is zeroed at the start of every packet.
- **Container conflicts:** if two valid actions hit the same container, the higher action index wins.
- **State machine:**
  - **CAPTURE** (beat counter 0..3):
    - Pass-through: m_axis_* = s_axis_*, m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready.
    - On each handshake, store the beat in buffer slot `cnt` and increment cnt.
    - Go to LOOKUP on tlast, or on the handshake of beat 3.
  - **LOOKUP:** s_axis_tready = 0; register the table entry for vlan_id[7:4]. Go to EXTRACT.
  - **EXTRACT:** s_axis_tready = 0; register all 10 extractions and the metadata into phv_out. Go to EMIT.
  - **EMIT:**
    - phv_out_valid = 1; phv_out stays stable until phv_out_ready.
    - On handshake: if the packet already ended (tlast captured), go to CAPTURE with cnt = 0; otherwise go to PASS.
  - **PASS:** pass-through as in CAPTURE, without storing beats. Go to CAPTURE on the tlast handshake.
- **Ordering:** one PHV per packet. The PHV is emitted in packet order, and always after that packet's first ≤4 beats have been written to m_axis.

## Timing
- **Reset values:**
  - state = CAPTURE, cnt = 0.
  - phv_out = 0, phv_out_valid = 0.
  - m_axis_tvalid = 0 and s_axis_tready = 0 while aresetn is low.
  - Table cleared.
- **Latency:** last captured beat accepted at cycle T → LOOKUP at T+1, EXTRACT at T+2, phv_out_valid high at T+3.
- **Ingress bubble:** s_axis_tready is 0 for at least 3 cycles per packet, during LOOKUP, EXTRACT and EMIT.
- **Pass-through path:** m_axis is combinational from s_axis in CAPTURE and PASS. A beat moves only when s_axis_tvalid && m_axis_tready.
- **Table write collision:** a ctrl write in the same cycle as LOOKUP to the same entry → LOOKUP uses the old contents.
- **Reset mid-packet:** returns to CAPTURE and drops any pending PHV. Upstream restarts at a packet boundary.
- **Single-beat packet:** tlast on beat 0 → beats 1..3 are zero.

## Test plan
- **2B extraction:** entry 3 action0 = {offset 12, type 01, idx 0, valid}. Send a 4-beat packet with vlan_id 0x035 and bytes 12..13 = 0x08,0x00. Expect:
  - PHV[356+:16] = 0x0800.
  - PHV[129+:12] = 0x035.
  - PHV[0+:128] = beat-0 tuser.
  - phv_out_valid 3 cycles after beat 3.
- **6B and 4B extraction, 6-beat packet:** action1 = 6B, idx 2, offset 26; action2 = 4B, idx 7, offset 120. Expect:
  - PHV[740+96+:48] = bytes 26..31, MSB-first.
  - PHV[484+224+:32] = bytes 120..123.
  - All 6 beats appear on m_axis unchanged.
  - One PHV only.
- **Short packet and out-of-range:** single-beat packet with a 2B action at offset 40 → container = 0x0000. Action at offset 127, type 4B → container = {byte127, 0x00, 0x00, 0x00}.
- **Conflict:** action0 and action5 both target 2B idx 1 → container holds action5's field.
- **Backpressure:**
  - Hold m_axis_tready = 0 for 5 cycles mid-capture → no beat lost or duplicated.
  - Hold phv_out_ready = 0 for 10 cycles → phv_out stable and s_axis_tready = 0 throughout.
  - Next packet starts cleanly.
- **Reset mid-PASS, then table write:** assert aresetn low mid-PASS → all outputs go to their reset values. Then write entry 0 in the cycle before LOOKUP → the new actions apply.

Source files
------------

// File: rtl/pkt_header_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pkt_header_parser
// Passes AXI4-Stream packets straight through, captures the first 128 bytes
// and builds a PHV from a VLAN-indexed parse-action table.
// Rev 1.0
// ----------------------------------------------------------------------------
module pkt_header_parser #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_PKT_VEC_WIDTH    = 1124
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [C_PKT_VEC_WIDTH-1:0]     phv_out,
  output logic                           phv_out_valid,
  input  logic                           phv_out_ready,
  input  logic                           ctrl_wr_en,
  input  logic [3:0]                     ctrl_wr_addr,
  input  logic [159:0]                   ctrl_wr_data
);

  localparam int BUF_W  = 4 * C_AXIS_DATA_WIDTH;
  localparam int N_ACT  = 10;
  localparam int ACT_W  = 13;
  localparam int OFF_C2 = 356;
  localparam int OFF_C4 = 484;
  localparam int OFF_C6 = 740;

  typedef enum logic [2:0] {
    S_CAPTURE = 3'd0,
    S_LOOKUP  = 3'd1,
    S_EXTRACT = 3'd2,
    S_EMIT    = 3'd3,
    S_PASS    = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      cnt_q, cnt_d;
  logic                            last_q, last_d;
  logic [BUF_W-1:0]                buf_q, buf_d;
  logic [C_AXIS_TUSER_WIDTH-1:0]   tuser0_q, tuser0_d;
  logic [ACT_W-1:0]                entry_q [N_ACT];
  logic [ACT_W-1:0]                entry_d [N_ACT];
  logic [C_PKT_VEC_WIDTH-1:0]      phv_q, phv_d, phv_x;
  logic [ACT_W-1:0]                tbl_q [16][N_ACT];
  logic [11:0]                     vlan_id;
  logic                            hs;
  logic [ACT_W-1:0]                x_act;
  logic [47:0]                     x_fld;
  logic [3*N_ACT-1:0]              rsvd_bits;
  logic                            unused_rsvd;

  // Bits [15:13] of every action are reserved and never stored.
  always_comb begin
    rsvd_bits = '0;
    for (int i = 0; i < N_ACT; i++) rsvd_bits[3*i +: 3] = ctrl_wr_data[16*i+13 +: 3];
  end
  assign unused_rsvd = ^rsvd_bits;

  assign vlan_id = {buf_q[112 +: 4], buf_q[120 +: 8]};
  assign hs      = s_axis_tvalid && m_axis_tready;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign phv_out       = phv_q;
  assign phv_out_valid = aresetn && (state_q == S_EMIT);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int e = 0; e < 16; e++)
        for (int i = 0; i < N_ACT; i++) tbl_q[e][i] <= '0;
    end else if (ctrl_wr_en) begin
      for (int i = 0; i < N_ACT; i++) tbl_q[ctrl_wr_addr][i] <= ctrl_wr_data[16*i +: ACT_W];
    end
  end

  // n-byte field at off, MSB byte first; bytes beyond the 128-byte window read 0.
  function automatic logic [47:0] field_at(input logic [BUF_W-1:0] b, input logic [6:0] off);
    logic [7:0] pos;
    field_at = '0;
    for (int j = 0; j < 6; j++) begin
      pos = {1'b0, off} + 8'(j);
      if (!pos[7]) field_at[47-8*j -: 8] = b[{pos[6:0], 3'b000} +: 8];
    end
  endfunction

  // Ascending action order lets the higher index win a container conflict.
  always_comb begin
    phv_x = '0;
    x_act = '0;
    x_fld = '0;
    phv_x[C_AXIS_TUSER_WIDTH-1:0] = tuser0_q;
    phv_x[129 +: 12]              = vlan_id;
    for (int i = 0; i < N_ACT; i++) begin
      x_act = entry_q[i];
      x_fld = field_at(buf_q, x_act[12:6]);
      if (x_act[0]) begin
        case (x_act[5:4])
          2'b01:   phv_x[OFF_C2 + 16*int'(x_act[3:1]) +: 16] = x_fld[47:32];
          2'b10:   phv_x[OFF_C4 + 32*int'(x_act[3:1]) +: 32] = x_fld[47:16];
          2'b11:   phv_x[OFF_C6 + 48*int'(x_act[3:1]) +: 48] = x_fld;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    buf_d         = buf_q;
    tuser0_d      = tuser0_q;
    entry_d       = entry_q;
    phv_d         = phv_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        if (hs) begin
          if (cnt_q == 2'd0) begin
            buf_d    = '0;
            tuser0_d = s_axis_tuser;
          end
          buf_d[{cnt_q, 8'h00} +: C_AXIS_DATA_WIDTH] = s_axis_tdata;
          cnt_d  = cnt_q + 2'd1;
          last_d = s_axis_tlast;
          if (s_axis_tlast || cnt_q == 2'd3) begin
            state_d = S_LOOKUP;
            cnt_d   = 2'd0;
          end
        end
      end
      S_LOOKUP: begin
        for (int i = 0; i < N_ACT; i++) entry_d[i] = tbl_q[vlan_id[7:4]][i];
        state_d = S_EXTRACT;
      end
      S_EXTRACT: begin
        phv_d   = phv_x;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (phv_out_ready) state_d = last_q ? S_CAPTURE : S_PASS;
      end
      S_PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        if (hs && s_axis_tlast) state_d = S_CAPTURE;
      end
      default: state_d = S_CAPTURE;
    endcase
    if (!aresetn) begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= S_CAPTURE;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      buf_q    <= '0;
      tuser0_q <= '0;
      phv_q    <= '0;
      for (int i = 0; i < N_ACT; i++) entry_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      buf_q    <= buf_d;
      tuser0_q <= tuser0_d;
      phv_q    <= phv_d;
      entry_q  <= entry_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_header_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pkt_header_parser
// Directed packets with hand-computed PHVs; queued expectations are popped
// by independent beat and PHV monitors.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pkt_header_parser;

  localparam int PW = 1124;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [255:0]  s_axis_tdata = '0;
  logic [31:0]   s_axis_tkeep = '0;
  logic [127:0]  s_axis_tuser = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [255:0]  m_axis_tdata;
  logic [31:0]   m_axis_tkeep;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [PW-1:0] phv_out;
  logic          phv_out_valid;
  logic          phv_out_ready = 1'b1;
  logic          ctrl_wr_en = 1'b0;
  logic [3:0]    ctrl_wr_addr = '0;
  logic [159:0]  ctrl_wr_data = '0;

  always #5 clk = ~clk;

  pkt_header_parser dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_ready(phv_out_ready),
    .ctrl_wr_en(ctrl_wr_en), .ctrl_wr_addr(ctrl_wr_addr), .ctrl_wr_data(ctrl_wr_data)
  );

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t         beat_q[$];
  logic [PW-1:0] phv_exp_q[$];
  int            checks = 0;
  int            passes = 0;
  int            cyc = 0;
  int            last_cap_cyc = 0;
  logic [7:0]    pkt [256];
  int            bp_beat = -1;
  int            bp_len = 0;
  bit            wr_on_cap = 1'b0;
  logic [3:0]    wr_addr_g = '0;
  logic [159:0]  wr_data_g = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [PW-1:0] base_phv(input logic [127:0] tu, input logic [11:0] vlan);
    base_phv = '0;
    base_phv[127:0]    = tu;
    base_phv[129 +: 12] = vlan;
  endfunction

  task automatic fill(input logic [7:0] seed);
    for (int g = 0; g < 256; g++) pkt[g] = 8'(g) + seed;
  endtask

  task automatic tbl_write(input logic [3:0] a, input logic [159:0] d);
    ctrl_wr_en = 1'b1; ctrl_wr_addr = a; ctrl_wr_data = d;
    @(posedge clk); #1;
    ctrl_wr_en = 1'b0;
  endtask

  // Sends the first nsend beats of an nb-beat packet built from pkt[].
  task automatic send_pkt(input int nb, input logic [127:0] tu, input int nsend);
    beat_t bt;
    bit    cap_end;
    int    guard;
    for (int b = 0; b < nsend; b++) begin
      for (int j = 0; j < 32; j++) bt.d[8*j +: 8] = pkt[32*b+j];
      bt.k = '1;
      bt.u = (b == 0) ? tu : {4{32'(b)}};
      bt.l = (b == nb-1);
      s_axis_tdata = bt.d; s_axis_tkeep = bt.k; s_axis_tuser = bt.u;
      s_axis_tlast = bt.l; s_axis_tvalid = 1'b1;
      beat_q.push_back(bt);
      cap_end = (b == ((nb < 4) ? nb : 4) - 1);
      if (cap_end && wr_on_cap) begin
        ctrl_wr_en = 1'b1; ctrl_wr_addr = wr_addr_g; ctrl_wr_data = wr_data_g;
      end
      if (b == bp_beat) begin
        m_axis_tready = 1'b0;
        repeat (bp_len) begin
          @(negedge clk);
          check("bp_s_tready", 768'(s_axis_tready), 768'(0));
          @(posedge clk); #1;
        end
        m_axis_tready = 1'b1;
      end
      guard = 0;
      @(negedge clk);
      while (!s_axis_tready) begin
        guard++;
        if (guard > 200) begin
          $display("FAIL send_timeout: beat %0d not accepted after %0d cycles, required acceptance", b, guard);
          $fatal(1, "ingress stalled");
        end
        @(negedge clk);
      end
      if (cap_end) last_cap_cyc = cyc;
      @(posedge clk); #1;
      ctrl_wr_en = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Beat monitor
  always @(negedge clk) begin
    beat_t e;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (beat_q.size() == 0) begin
        checks++;
        $display("FAIL m_axis_extra: got unexpected beat %0h expected none", m_axis_tdata);
      end else begin
        e = beat_q.pop_front();
        check("m_axis_beat", 768'({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}), 768'(e));
      end
    end
  end

  // PHV monitor
  logic [PW-1:0] held_phv = '0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  always @(negedge clk) begin
    logic [PW-1:0] e;
    if (!aresetn) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (phv_out_valid && !prev_valid) check_int("phv_latency", cyc - last_cap_cyc, 3);
      if (phv_out_valid && prev_valid && !prev_ready) begin
        check("phv_stable_lo", 768'(phv_out[355:0]), 768'(held_phv[355:0]));
        check("phv_stable_hi", 768'(phv_out[1123:356]), 768'(held_phv[1123:356]));
        check("stall_s_tready", 768'(s_axis_tready), 768'(0));
      end
      if (phv_out_valid && phv_out_ready) begin
        if (phv_exp_q.size() == 0) begin
          checks++;
          $display("FAIL phv_extra: got unexpected PHV tuser %0h expected none", phv_out[127:0]);
        end else begin
          e = phv_exp_q.pop_front();
          check("phv_tuser", 768'(phv_out[127:0]), 768'(e[127:0]));
          check("phv_meta", 768'(phv_out[355:128]), 768'(e[355:128]));
          check("phv_c2", 768'(phv_out[483:356]), 768'(e[483:356]));
          check("phv_c4", 768'(phv_out[739:484]), 768'(e[739:484]));
          check("phv_c6", 768'(phv_out[1123:740]), 768'(e[1123:740]));
        end
      end
      prev_valid = phv_out_valid;
      prev_ready = phv_out_ready;
      held_phv   = phv_out;
    end
  end

  initial begin
    logic [PW-1:0]  exp;
    logic [159:0]   d;
    logic [127:0]   tu;

    // Reset with ingress valid held high: outputs must stay quiet.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {8{32'hDEADBEEF}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 768'(m_axis_tvalid), 768'(0));
    check("rst_s_tready", 768'(s_axis_tready), 768'(0));
    check("rst_phv_valid", 768'(phv_out_valid), 768'(0));
    check("rst_phv_lo", 768'(phv_out[355:0]), 768'(0));
    check("rst_phv_hi", 768'(phv_out[1123:356]), 768'(0));
    s_axis_tvalid = 1'b0;
    aresetn = 1'b1;
    @(negedge clk);
    check("post_rst_s_tready", 768'(s_axis_tready), 768'(1));
    @(posedge clk); #1;

    // 2B extraction: entry 3, action0 = offset 12, 2B, idx 0.
    tbl_write(4'd3, 160'h0311);
    fill(8'h00);
    pkt[12] = 8'h08; pkt[13] = 8'h00; pkt[14] = 8'h00; pkt[15] = 8'h35;
    tu = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    exp = base_phv(tu, 12'h035);
    exp[356 +: 16] = 16'h0800;
    phv_exp_q.push_back(exp);
    send_pkt(4, tu, 4);
    repeat (4) @(posedge clk);
    #1;

    // 6B idx2 @26 and 4B idx7 @120 on a 6-beat packet, entry 5.
    tbl_write(4'd5, 160'h1E2F_06B5_0000);
    fill(8'h10);
    pkt[14] = 8'h81; pkt[15] = 8'h52;
    tu = 128'hAAAA_0000_BBBB_1111_CCCC_2222_DDDD_3333;
    exp = base_phv(tu, 12'h152);
    exp[836 +: 48] = 48'h2A2B2C2D2E2F;
    exp[708 +: 32] = 32'h88898A8B;
    phv_exp_q.push_back(exp);
    send_pkt(6, tu, 6);
    repeat (3) @(posedge clk);
    #1;

    // Entry 6: 2B idx3 @40, 4B idx0 @127. Single-beat packet sees zeros.
    tbl_write(4'd6, 160'h1FE1_0A17);
    fill(8'h30);
    pkt[14] = 8'h00; pkt[15] = 8'h61;
    tu = 128'h5555;
    phv_exp_q.push_back(base_phv(tu, 12'h061));
    send_pkt(1, tu, 1);
    repeat (6) @(posedge clk);
    #1;
    fill(8'h30);
    pkt[14] = 8'h00; pkt[15] = 8'h6C;
    tu = 128'h6666_7777;
    exp = base_phv(tu, 12'h06C);
    exp[404 +: 16] = 16'h5859;
    exp[484 +: 32] = 32'hAF000000;
    phv_exp_q.push_back(exp);
    send_pkt(4, tu, 4);
    repeat (4) @(posedge clk);
    #1;

    // Conflict on 2B idx1 (action0 @20 vs action5 @50) with both backpressures.
    d = '0;
    d[15:0]  = 16'h0513;
    d[95:80] = 16'h0C93;
    tbl_write(4'd7, d);
    fill(8'h00);
    pkt[14] = 8'h00; pkt[15] = 8'h7F;
    tu = 128'h7777_0000_0000_0007;
    exp = base_phv(tu, 12'h07F);
    exp[372 +: 16] = 16'h3233;
    phv_exp_q.push_back(exp);
    phv_out_ready = 1'b0;
    bp_beat = 2; bp_len = 5;
    send_pkt(4, tu, 4);
    bp_beat = -1;
    repeat (13) @(posedge clk);
    #1;
    phv_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset while in PASS on beat 4 of a 6-beat packet.
    fill(8'h40);
    pkt[14] = 8'h00; pkt[15] = 8'h35;
    tu = 128'h8888;
    exp = base_phv(tu, 12'h035);
    exp[356 +: 16] = 16'h4C4D;
    phv_exp_q.push_back(exp);
    send_pkt(6, tu, 5);
    s_axis_tdata = {8{32'hCAFEF00D}};
    s_axis_tvalid = 1'b1;
    aresetn = 1'b0;
    @(negedge clk);
    check("mid_rst_m_tvalid", 768'(m_axis_tvalid), 768'(0));
    check("mid_rst_s_tready", 768'(s_axis_tready), 768'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_phv_valid", 768'(phv_out_valid), 768'(0));
    check("mid_rst_phv_lo", 768'(phv_out[355:0]), 768'(0));
    check("mid_rst_phv_hi", 768'(phv_out[1123:356]), 768'(0));
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Table must have been cleared: entry 3 no longer extracts.
    fill(8'h00);
    pkt[14] = 8'h00; pkt[15] = 8'h35;
    tu = 128'h9999;
    phv_exp_q.push_back(base_phv(tu, 12'h035));
    send_pkt(1, tu, 1);
    repeat (6) @(posedge clk);
    #1;

    // Entry 0 written in the cycle before LOOKUP: 6B idx0 @0.
    wr_on_cap = 1'b1; wr_addr_g = 4'd0; wr_data_g = 160'h0031;
    fill(8'h00);
    pkt[14] = 8'h00; pkt[15] = 8'h0A;
    tu = 128'hA0A0;
    exp = base_phv(tu, 12'h00A);
    exp[740 +: 48] = 48'h000102030405;
    phv_exp_q.push_back(exp);
    send_pkt(2, tu, 2);
    wr_on_cap = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    check_int("beats_left", beat_q.size(), 0);
    check_int("phvs_left", phv_exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected $finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
